mux_scan: RTL

Parametrised, registered N-channel, W-bit multiplexer for the VFSD datapath. It supports two modes: manual selection from a `sel` input, and automatic round-robin scanning with a programmable dwell time per channel. It reports the active channel and pulses a strobe on every channel change, so downstream displays and loggers can tag the data.

---
 rtl/mux_scan.sv | 81 ++++++++
 1 files changed

// File: rtl/mux_scan.sv
// N-channel registered multiplexer with manual select and round-robin scan.
// Reports the active channel and strobes for one cycle on every channel change.
module mux_scan #(
  parameter int unsigned N_CH  = 6,
  parameter int unsigned WIDTH = 1,
  parameter int unsigned DWELL = 4,
  localparam int unsigned SW   = (N_CH > 2) ? $clog2(N_CH) : 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    mode,
  input  logic [SW-1:0]           sel,
  input  logic                    en,
  input  logic [N_CH*WIDTH-1:0]   in_bus,
  output logic [WIDTH-1:0]        out_mux,
  output logic [SW-1:0]           ch_cur,
  output logic                    ch_strobe
);

  localparam int unsigned   DW        = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [DW-1:0] DCNT_LAST = DW'(DWELL - 1);
  localparam logic [SW-1:0] CH_LAST   = SW'(N_CH - 1);

  logic [DW-1:0]    dcnt;
  logic [DW-1:0]    dcnt_next;
  logic             mode_q;
  logic [SW-1:0]    ch_next;
  logic [WIDTH-1:0] data_next;
  logic             sel_ok;

  // Compare one bit wider so power-of-two N_CH does not wrap the bound to zero.
  always_comb begin
    sel_ok = ({1'b0, sel} < (SW + 1)'(N_CH));
  end

  // Next channel and dwell count; a mode change clears the count and holds the channel.
  always_comb begin
    ch_next   = ch_cur;
    dcnt_next = dcnt;
    if (!mode) begin
      ch_next   = sel_ok ? sel : '0;
      dcnt_next = '0;
    end else if (mode != mode_q) begin
      dcnt_next = '0;
    end else if (en) begin
      if (dcnt == DCNT_LAST) begin
        dcnt_next = '0;
        ch_next   = (ch_cur == CH_LAST) ? '0 : ch_cur + SW'(1);
      end else begin
        dcnt_next = dcnt + DW'(1);
      end
    end
  end

  // Data of the channel that becomes active at the coming edge.
  always_comb begin
    data_next = '0;
    for (int k = 0; k < int'(N_CH); k++) begin
      if (ch_next == SW'(k)) begin
        data_next = in_bus[k*WIDTH +: WIDTH];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ch_cur    <= '0;
      out_mux   <= '0;
      ch_strobe <= 1'b0;
      dcnt      <= '0;
      mode_q    <= 1'b0;
    end else begin
      ch_cur    <= ch_next;
      out_mux   <= data_next;
      ch_strobe <= (ch_next != ch_cur);
      dcnt      <= dcnt_next;
      mode_q    <= mode;
    end
  end

endmodule
